// File: rtl/time_set_ctrl.sv
// time_set_ctrl: key-driven editor for the clock time and the alarm time.
//
// Ports
//   clk, rst                  system clock, synchronous active-high reset
//   key_mode/key_up/key_ok    debounced one-cycle key pulses (ok > mode > up)
//   cur_*                     running time from the timekeeper (BCD hh:mm:ss)
//   set_time_finish           0 while the timekeeper should load set_*, else 1
//   set_*                     edited time (BCD hh:mm:ss)
//   clock_en, clock_*         alarm enable and alarm time (BCD hh:mm)
//   edit_field                current state code (0 RUN .. 5 ALM_MIN)
//   blink                     blanking phase for the field being edited
//
// All outputs come straight from registers.
module time_set_ctrl #(
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_mode,
    input  logic       key_up,
    input  logic       key_ok,
    input  logic [3:0] cur_hour_shi,
    input  logic [3:0] cur_hour_ge,
    input  logic [3:0] cur_min_shi,
    input  logic [3:0] cur_min_ge,
    input  logic [3:0] cur_sec_shi,
    input  logic [3:0] cur_sec_ge,
    output logic       set_time_finish,
    output logic [3:0] set_hour_shi,
    output logic [3:0] set_hour_ge,
    output logic [3:0] set_min_shi,
    output logic [3:0] set_min_ge,
    output logic [3:0] set_sec_shi,
    output logic [3:0] set_sec_ge,
    output logic       clock_en,
    output logic [3:0] clock_hour_shi,
    output logic [3:0] clock_hour_ge,
    output logic [3:0] clock_min_shi,
    output logic [3:0] clock_min_ge,
    output logic [2:0] edit_field,
    output logic       blink
);

    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        SET_HOUR = 3'd1,
        SET_MIN  = 3'd2,
        SET_SEC  = 3'd3,
        ALM_HOUR = 3'd4,
        ALM_MIN  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic            stf_q, stf_d;
    logic [5:0][3:0] set_q, set_d;     // [5:4] hour, [3:2] min, [1:0] sec
    logic [3:0][3:0] alm_q, alm_d;     // [3:2] hour, [1:0] min
    logic            en_q, en_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            blink_q, blink_d;

    logic [5:0][3:0] cur;
    logic            k_ok, k_mode, k_up;

    assign cur = {cur_hour_shi, cur_hour_ge, cur_min_shi, cur_min_ge, cur_sec_shi, cur_sec_ge};

    // Only the highest-priority key of a coincident set acts.
    assign k_ok   = key_ok;
    assign k_mode = key_mode & ~key_ok;
    assign k_up   = key_up & ~key_ok & ~key_mode;

    function automatic logic [7:0] inc_hour(input logic [7:0] v);
        if (v == 8'h23)            return 8'h00;
        else if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
        else                       return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] inc_60(input logic [7:0] v);
        if (v == 8'h59)            return 8'h00;
        else if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
        else                       return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_comb begin
        state_d = state_q;
        set_d   = set_q;
        alm_d   = alm_q;
        en_d    = en_q;

        if (state_q == RUN) begin
            if (k_ok) begin
                en_d = ~en_q;
            end else if (k_mode) begin
                state_d = SET_HOUR;
                set_d   = cur;
            end
        end else if (k_ok) begin
            state_d = RUN;
        end else if (k_mode) begin
            case (state_q)
                SET_HOUR: state_d = SET_MIN;
                SET_MIN:  state_d = SET_SEC;
                SET_SEC:  state_d = ALM_HOUR;
                ALM_HOUR: state_d = ALM_MIN;
                default:  state_d = RUN;
            endcase
        end else if (k_up) begin
            case (state_q)
                SET_HOUR: set_d[5:4] = inc_hour(set_q[5:4]);
                SET_MIN:  set_d[3:2] = inc_60(set_q[3:2]);
                SET_SEC:  set_d[1:0] = inc_60(set_q[1:0]);
                ALM_HOUR: alm_d[3:2] = inc_hour(alm_q[3:2]);
                ALM_MIN:  alm_d[1:0] = inc_60(alm_q[1:0]);
                default:  state_d = RUN;
            endcase
        end

        stf_d = !(state_d == SET_HOUR || state_d == SET_MIN || state_d == SET_SEC);

        // Restart the blink phase whenever the field changes or is bumped so
        // the digits being edited are shown immediately.
        cnt_d   = cnt_q;
        blink_d = blink_q;
        if (state_d != state_q || state_q == RUN || k_up) begin
            cnt_d   = '0;
            blink_d = 1'b0;
        end else if (cnt_q == CW'(BLINK_DIV - 1)) begin
            cnt_d   = '0;
            blink_d = ~blink_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            stf_q   <= 1'b1;
            set_q   <= '0;
            alm_q   <= '0;
            en_q    <= 1'b0;
            cnt_q   <= '0;
            blink_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stf_q   <= stf_d;
            set_q   <= set_d;
            alm_q   <= alm_d;
            en_q    <= en_d;
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
        end
    end

    assign set_time_finish = stf_q;
    assign {set_hour_shi, set_hour_ge, set_min_shi, set_min_ge, set_sec_shi, set_sec_ge} = set_q;
    assign clock_en = en_q;
    assign {clock_hour_shi, clock_hour_ge, clock_min_shi, clock_min_ge} = alm_q;
    assign edit_field = state_q;
    assign blink      = blink_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
module tb_time_set_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_mode, key_up, key_ok;
    logic [23:0] cur;
    logic        set_time_finish, clock_en, blink;
    logic [3:0]  shs, shg, sms, smg, sss, ssg, chs, chg, cms, cmg;
    logic [2:0]  edit_field;
    logic [23:0] set_o;
    logic [15:0] alm_o;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    time_set_ctrl #(.BLINK_DIV(4)) dut (
        .clk(clk), .rst(rst),
        .key_mode(key_mode), .key_up(key_up), .key_ok(key_ok),
        .cur_hour_shi(cur[23:20]), .cur_hour_ge(cur[19:16]),
        .cur_min_shi(cur[15:12]), .cur_min_ge(cur[11:8]),
        .cur_sec_shi(cur[7:4]), .cur_sec_ge(cur[3:0]),
        .set_time_finish(set_time_finish),
        .set_hour_shi(shs), .set_hour_ge(shg),
        .set_min_shi(sms), .set_min_ge(smg),
        .set_sec_shi(sss), .set_sec_ge(ssg),
        .clock_en(clock_en),
        .clock_hour_shi(chs), .clock_hour_ge(chg),
        .clock_min_shi(cms), .clock_min_ge(cmg),
        .edit_field(edit_field),
        .blink(blink)
    );

    assign set_o = {shs, shg, sms, smg, sss, ssg};
    assign alm_o = {chs, chg, cms, cmg};

    typedef struct {
        logic        m, u, o;
        logic [23:0] cur;
        logic [2:0]  f;
        logic        stf;
        logic [23:0] set;
        logic        en;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic m, u, o, input logic [23:0] c,
                                input logic [2:0] f, input logic stf,
                                input logic [23:0] s, input logic en);
        vec_t v;
        v.m = m; v.u = u; v.o = o; v.cur = c;
        v.f = f; v.stf = stf; v.set = s; v.en = en;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one key cycle at the falling edge, then settle just after the rising edge.
    task automatic apply(input logic m, input logic u, input logic o, input logic [23:0] c);
        @(negedge clk);
        key_mode = m; key_up = u; key_ok = o; cur = c;
        @(posedge clk);
        #1;
        key_mode = 1'b0; key_up = 1'b0; key_ok = 1'b0;
    endtask

    task automatic press(input logic m, input logic u, input logic o, input int n);
        for (int i = 0; i < n; i++) apply(m, u, o, cur);
    endtask

    initial begin
        rst = 1'b1; key_mode = 1'b0; key_up = 1'b0; key_ok = 1'b0; cur = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_field", 32'(edit_field), 32'd0);
        chk("rst_stf", 32'(set_time_finish), 32'd1);
        chk("rst_set", 32'(set_o), 32'h0);
        chk("rst_alarm", 32'(alm_o), 32'h0);
        chk("rst_en", 32'(clock_en), 32'd0);
        chk("rst_blink", 32'(blink), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        //           m  u  o  cur          f  stf set          en
        tv.push_back(mk(1, 0, 0, 24'h123456, 1, 0, 24'h123456, 0));
        tv.push_back(mk(0, 0, 1, 24'h123456, 0, 1, 24'h123456, 0));
        tv.push_back(mk(1, 0, 0, 24'h235959, 1, 0, 24'h235959, 0));
        tv.push_back(mk(0, 1, 0, 24'h235959, 1, 0, 24'h005959, 0)); // 23 -> 00
        tv.push_back(mk(0, 0, 1, 24'h235959, 0, 1, 24'h005959, 0));
        tv.push_back(mk(1, 0, 0, 24'h094559, 1, 0, 24'h094559, 0));
        tv.push_back(mk(0, 1, 0, 24'h094559, 1, 0, 24'h104559, 0)); // 09 -> 10
        tv.push_back(mk(0, 1, 0, 24'h094559, 1, 0, 24'h114559, 0));
        tv.push_back(mk(1, 0, 0, 24'h094559, 2, 0, 24'h114559, 0));
        tv.push_back(mk(1, 1, 0, 24'h094559, 3, 0, 24'h114559, 0)); // mode beats up
        tv.push_back(mk(0, 1, 0, 24'h094559, 3, 0, 24'h114500, 0)); // sec 59 -> 00
        tv.push_back(mk(0, 1, 0, 24'h094559, 3, 0, 24'h114501, 0));
        tv.push_back(mk(1, 0, 0, 24'h094559, 4, 1, 24'h114501, 0));
        tv.push_back(mk(1, 0, 0, 24'h094559, 5, 1, 24'h114501, 0));
        tv.push_back(mk(1, 0, 0, 24'h094559, 0, 1, 24'h114501, 0));
        tv.push_back(mk(0, 1, 0, 24'h094559, 0, 1, 24'h114501, 0)); // up in RUN: no-op
        tv.push_back(mk(0, 0, 1, 24'h094559, 0, 1, 24'h114501, 1));
        tv.push_back(mk(0, 0, 1, 24'h094559, 0, 1, 24'h114501, 0));
        tv.push_back(mk(1, 0, 0, 24'h000000, 1, 0, 24'h000000, 0));
        tv.push_back(mk(1, 0, 0, 24'h000000, 2, 0, 24'h000000, 0));
        tv.push_back(mk(0, 1, 0, 24'h000000, 2, 0, 24'h000100, 0));
        tv.push_back(mk(1, 0, 1, 24'h000000, 0, 1, 24'h000100, 0)); // ok beats mode, en kept
        tv.push_back(mk(0, 1, 1, 24'h000000, 0, 1, 24'h000100, 1)); // ok beats up in RUN
        tv.push_back(mk(0, 0, 1, 24'h000000, 0, 1, 24'h000100, 0));

        foreach (tv[i]) begin
            apply(tv[i].m, tv[i].u, tv[i].o, tv[i].cur);
            chk($sformatf("v%0d_field", i), 32'(edit_field), 32'(tv[i].f));
            chk($sformatf("v%0d_stf", i), 32'(set_time_finish), 32'(tv[i].stf));
            chk($sformatf("v%0d_set", i), 32'(set_o), 32'(tv[i].set));
            chk($sformatf("v%0d_en", i), 32'(clock_en), 32'(tv[i].en));
        end

        // Alarm entry: 07:30, then enable.
        press(1, 0, 0, 4);
        chk("alm_field4", 32'(edit_field), 32'd4);
        chk("alm_stf4", 32'(set_time_finish), 32'd1);
        press(0, 1, 0, 7);
        press(1, 0, 0, 1);
        chk("alm_field5", 32'(edit_field), 32'd5);
        press(0, 1, 0, 30);
        press(0, 0, 1, 1);
        chk("alm_0730", 32'(alm_o), 32'h0730);
        chk("alm_run", 32'(edit_field), 32'd0);
        chk("alm_en_hold", 32'(clock_en), 32'd0);
        press(0, 0, 1, 1);
        chk("alm_en_on", 32'(clock_en), 32'd1);

        // Alarm minute 59 -> 00, hour untouched.
        press(1, 0, 0, 5);
        press(0, 1, 0, 29);
        chk("alm_0759", 32'(alm_o), 32'h0759);
        press(0, 1, 0, 1);
        chk("alm_min_wrap", 32'(alm_o), 32'h0700);
        press(1, 0, 0, 1);
        chk("alm_back_run", 32'(edit_field), 32'd0);

        // Alarm hour 23 -> 00, minute untouched.
        press(1, 0, 0, 4);
        press(0, 1, 0, 16);
        chk("alm_2300", 32'(alm_o), 32'h2300);
        press(0, 1, 0, 1);
        chk("alm_hour_wrap", 32'(alm_o), 32'h0000);
        press(0, 0, 1, 1);
        chk("alm_en_kept", 32'(clock_en), 32'd1);

        // Blink with BLINK_DIV=4: toggles every 4 cycles after entering SET_HOUR.
        apply(1, 0, 0, 24'h123456);
        chk("blk_k0", 32'(blink), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            apply(0, 0, 0, cur);
            chk($sformatf("blk_k%0d", k), 32'(blink), (k >= 4) ? 32'd1 : 32'd0);
        end
        apply(0, 1, 0, cur);
        chk("blk_up_clear", 32'(blink), 32'd0);
        chk("blk_up_hour", 32'(set_o), 32'h133456);
        for (int k = 1; k <= 4; k++) begin
            apply(0, 0, 0, cur);
            chk($sformatf("blk_r%0d", k), 32'(blink), (k == 4) ? 32'd1 : 32'd0);
        end

        // Reset mid-edit, with keys asserted that must be ignored.
        @(negedge clk);
        rst = 1'b1; key_mode = 1'b1; key_ok = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_stf", 32'(set_time_finish), 32'd1);
        chk("mrst_en", 32'(clock_en), 32'd0);
        chk("mrst_field", 32'(edit_field), 32'd0);
        chk("mrst_blink", 32'(blink), 32'd0);
        chk("mrst_set", 32'(set_o), 32'h0);
        @(posedge clk);
        #1;
        chk("mrst_keys_ignored", 32'({edit_field, clock_en}), 32'd0);
        @(negedge clk);
        rst = 1'b0; key_mode = 1'b0; key_ok = 1'b0;
        apply(0, 0, 0, cur);
        chk("post_rst_field", 32'(edit_field), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
